// File: rtl/trace_rr_arbiter.sv
// trace_rr_arbiter
//   Round-robin arbiter sharing one cache-simulator core between NUM_CORES
//   trace sources. A grant latches the winner's address, issues a one-cycle
//   trace_ready strobe, waits for the cache completion strobe and returns a
//   one-cycle ack carrying the hit/miss result to the granted core.
//
// Parameters
//   NUM_CORES  number of requesters (2..16)
//   ADDR_W     address width
//   CNT_W      statistics counter width (counters saturate)
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req, addr         per-core request and packed per-core address
//   ack, ack_hit      completion pulse to the granted core and its result
//   busy, gnt_id      not-idle flag, index of current/last granted core
//   trace_ready       one-cycle issue strobe to the cache
//   mem_addr          address to the cache, stable from ISSUE through RESP
//   found_in_cache    cache hit-completion strobe
//   updated_cache     cache miss-completion strobe
//   total_req_count   completed transactions
//   core_hit_cnt      per-core hit counts   (ARB_CORE_STATS_EN only, else 0)
//   core_miss_cnt     per-core miss counts  (ARB_CORE_STATS_EN only, else 0)
//
// Build option
//   ARB_CORE_STATS_EN  builds the per-core saturating hit/miss counters.
module trace_rr_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  output logic [NUM_CORES-1:0]          ack,
  output logic                          ack_hit,
  output logic                          busy,
  output logic [$clog2(NUM_CORES)-1:0]  gnt_id,
  output logic                          trace_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          found_in_cache,
  input  logic                          updated_cache,
  output logic [CNT_W-1:0]              total_req_count,
  output logic [NUM_CORES*CNT_W-1:0]    core_hit_cnt,
  output logic [NUM_CORES*CNT_W-1:0]    core_miss_cnt
);

  localparam int unsigned IDW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         last_gnt_q, last_gnt_d;
  logic [IDW-1:0]         gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   trace_ready_q, trace_ready_d;
  logic                   busy_q, busy_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic                   ack_hit_q, ack_hit_d;
  logic [CNT_W-1:0]       total_q, total_d;

  logic [IDW-1:0]         sel;
  logic                   sel_vld;
  logic                   strobe;

  assign strobe = found_in_cache | updated_cache;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int unsigned     off);
    int unsigned s;
    s = (32'(base) + off) % NUM_CORES;
    return IDW'(s);
  endfunction

  // Scan from the farthest offset down to last_gnt+1 so the nearest
  // requester above the last grant overwrites any farther one.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned off = NUM_CORES; off >= 1; off--) begin
      if (req[wrap_idx(last_gnt_q, off)]) begin
        sel     = wrap_idx(last_gnt_q, off);
        sel_vld = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sel_vld) state_d = S_ISSUE;
      S_ISSUE: state_d = strobe ? S_RESP : S_WAIT;
      S_WAIT:  if (strobe) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: every output is a register, so the values for the
  // coming state are computed here from the transition being taken.
  always_comb begin
    gnt_id_d      = gnt_id_q;
    mem_addr_d    = mem_addr_q;
    last_gnt_d    = last_gnt_q;
    total_d       = total_q;
    trace_ready_d = (state_d == S_ISSUE);
    busy_d        = (state_d != S_IDLE);
    ack_d         = '0;
    ack_hit_d     = 1'b0;

    if (state_q == S_IDLE && sel_vld) begin
      gnt_id_d   = sel;
      mem_addr_d = addr[32'(sel)*ADDR_W +: ADDR_W];
    end

    // found_in_cache wins when both strobes arrive together.
    if (state_d == S_RESP) begin
      ack_d[gnt_id_q] = 1'b1;
      ack_hit_d       = found_in_cache;
    end

    if (state_q == S_RESP) begin
      last_gnt_d = gnt_id_q;
      if (total_q != '1) total_d = total_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q    <= IDW'(NUM_CORES - 1);
      gnt_id_q      <= '0;
      mem_addr_q    <= '0;
      trace_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= '0;
      ack_hit_q     <= 1'b0;
      total_q       <= '0;
    end else begin
      last_gnt_q    <= last_gnt_d;
      gnt_id_q      <= gnt_id_d;
      mem_addr_q    <= mem_addr_d;
      trace_ready_q <= trace_ready_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      ack_hit_q     <= ack_hit_d;
      total_q       <= total_d;
    end
  end

  assign ack             = ack_q;
  assign ack_hit         = ack_hit_q;
  assign busy            = busy_q;
  assign gnt_id          = gnt_id_q;
  assign trace_ready     = trace_ready_q;
  assign mem_addr        = mem_addr_q;
  assign total_req_count = total_q;

`ifdef ARB_CORE_STATS_EN
  // ack_hit_q holds the result throughout RESP, so the per-core update
  // happens on the same edge as total_req_count.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_stats
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hit_q  <= '0;
        miss_q <= '0;
      end else if (state_q == S_RESP && gnt_id_q == IDW'(g)) begin
        if (ack_hit_q && hit_q != '1)   hit_q  <= hit_q + CNT_W'(1);
        if (!ack_hit_q && miss_q != '1) miss_q <= miss_q + CNT_W'(1);
      end
    end

    assign core_hit_cnt[g*CNT_W +: CNT_W]  = hit_q;
    assign core_miss_cnt[g*CNT_W +: CNT_W] = miss_q;
  end
`else
  assign core_hit_cnt  = '0;
  assign core_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_trace_rr_arbiter.sv
`timescale 1ns/1ps
module tb_trace_rr_arbiter;

  localparam int NC   = 4;
  localparam int AW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req;
  logic [NC*AW-1:0]  addr_bus;
  logic [NC-1:0]     ack;
  logic              ack_hit, busy, trace_ready;
  logic [IDW-1:0]    gnt_id;
  logic [AW-1:0]     mem_addr;
  logic              found_r, upd_r, found_s;
  logic              found_in_cache, updated_cache;
  logic [CW-1:0]     total_req_count;
  logic [NC*CW-1:0]  core_hit_cnt, core_miss_cnt;

  logic [AW-1:0]     addr_m [NC];
  logic [NC-1:0]     req_s;

  assign found_in_cache = found_r | found_s;
  assign updated_cache  = upd_r;

  always_comb
    for (int i = 0; i < NC; i++) addr_bus[i*AW +: AW] = addr_m[i];

  // Request vector as the DUT saw it at the last rising edge.
  always @(posedge clk) req_s <= req;

  always #5 clk = ~clk;

  trace_rr_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .addr            (addr_bus),
    .ack             (ack),
    .ack_hit         (ack_hit),
    .busy            (busy),
    .gnt_id          (gnt_id),
    .trace_ready     (trace_ready),
    .mem_addr        (mem_addr),
    .found_in_cache  (found_in_cache),
    .updated_cache   (updated_cache),
    .total_req_count (total_req_count),
    .core_hit_cnt    (core_hit_cnt),
    .core_miss_cnt   (core_miss_cnt)
  );

  typedef struct { int core; bit hit; } exp_t;
  exp_t exp_q[$];
  int   rd_idx;
  int   glog[$];

  int n_vec, n_mis;
  int mlast, tot_m;
  int hit_m [NC];
  int miss_m [NC];
  int left [NC];
  bit rnd;
  int cfg_kind;      // 0 found, 1 updated, 2 both, 3 random of 0..2, 4 never answer
  int cfg_lat;
  bit cfg_lat_rnd;
  int r_cnt, r_g, r_kind;
  bit r_drop, r_trchk, cnt_chk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Round-robin rule: first requesting core after the last grant, wrapping.
  function automatic int pick(input logic [NC-1:0] r, input int last);
    for (int k = 1; k <= NC; k++) begin
      int c;
      c = (last + k) % NC;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_counters();
    chk("total_req_count", 64'(total_req_count), 64'(tot_m));
    for (int i = 0; i < NC; i++) begin
`ifdef ARB_CORE_STATS_EN
      chk($sformatf("core_hit_cnt[%0d]", i),  64'(core_hit_cnt[i*CW +: CW]),  64'(hit_m[i]));
      chk($sformatf("core_miss_cnt[%0d]", i), 64'(core_miss_cnt[i*CW +: CW]), 64'(miss_m[i]));
`else
      chk($sformatf("core_hit_cnt[%0d]", i),  64'(core_hit_cnt[i*CW +: CW]),  64'(0));
      chk($sformatf("core_miss_cnt[%0d]", i), 64'(core_miss_cnt[i*CW +: CW]), 64'(0));
`endif
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an ack.
  task automatic mon_step();
    exp_t e;
    if (cnt_chk) begin
      cnt_chk = 1'b0;
      chk_counters();
    end
    if (ack != '0) begin
      if (rd_idx >= exp_q.size()) begin
        chk("unexpected_ack", 64'(ack), 64'(0));
      end else begin
        e = exp_q[rd_idx];
        rd_idx++;
        chk("ack_vector", 64'(ack), 64'(1) << e.core);
        chk("ack_hit", 64'(ack_hit), 64'(e.hit));
        chk("busy_at_ack", 64'(busy), 64'(1));
        if (tot_m < CMAX) tot_m++;
        if (e.hit) begin
          if (hit_m[e.core] < CMAX) hit_m[e.core]++;
        end else begin
          if (miss_m[e.core] < CMAX) miss_m[e.core]++;
        end
        cnt_chk = 1'b1;
      end
    end
  endtask

  // Cache responder: predicts the grant, answers after a latency and
  // pushes the expected acknowledge.
  task automatic resp_step();
    int g;
    if (r_drop) begin
      found_r = 1'b0;
      upd_r   = 1'b0;
      r_drop  = 1'b0;
    end
    if (r_trchk) begin
      r_trchk = 1'b0;
      chk("trace_ready_width", 64'(trace_ready), 64'(0));
    end
    if (r_cnt < 0 && trace_ready) begin
      g = pick(req_s, mlast);
      chk("grant_has_requester", 64'(g >= 0), 64'(1));
      if (g >= 0) begin
        chk("gnt_id", 64'(gnt_id), 64'(g));
        chk("mem_addr", 64'(mem_addr), 64'(addr_m[g]));
        chk("busy_at_issue", 64'(busy), 64'(1));
        mlast = g;
        glog.push_back(g);
        r_g     = g;
        r_trchk = 1'b1;
        r_kind  = (cfg_kind == 3) ? int'($urandom_range(0, 2)) : cfg_kind;
        if (r_kind == 4) r_cnt = -1;
        else r_cnt = cfg_lat_rnd ? int'($urandom_range(0, 4)) : cfg_lat;
      end
    end
    if (r_cnt == 0) begin
      found_r = (r_kind != 1);
      upd_r   = (r_kind != 0);
      exp_q.push_back('{core: r_g, hit: (r_kind != 1)});
      r_drop = 1'b1;
      r_cnt  = -1;
    end else if (r_cnt > 0) begin
      r_cnt--;
    end
  endtask

  // Requesters: hold req until ack; re-request while transactions remain.
  task automatic drv_step();
    for (int i = 0; i < NC; i++) begin
      if (ack[i]) begin
        if (left[i] > 0) left[i]--;
        if (left[i] == 0 || (rnd && $urandom_range(0, 1) == 1)) req[i] = 1'b0;
        else if (rnd) addr_m[i] = $urandom;
      end else if (!req[i] && left[i] > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
        req[i] = 1'b1;
        if (rnd) addr_m[i] = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    resp_step();
    drv_step();
  endtask

  function automatic bit quiet();
    for (int i = 0; i < NC; i++) if (left[i] != 0) return 1'b0;
    return (req == '0) && !busy && r_cnt < 0 && !r_drop && !cnt_chk
           && rd_idx == exp_q.size();
  endfunction

  task automatic run_phase(input int budget, input string nm);
    int cyc;
    cyc = 0;
    while (!quiet()) begin
      tick();
      cyc++;
      if (cyc > budget) begin
        chk({nm, "_cycle_budget"}, 64'(cyc), 64'(budget));
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},         64'(ack),             64'(0));
    chk({tag, "_ack_hit"},     64'(ack_hit),         64'(0));
    chk({tag, "_busy"},        64'(busy),            64'(0));
    chk({tag, "_trace_ready"}, 64'(trace_ready),     64'(0));
    chk({tag, "_mem_addr"},    64'(mem_addr),        64'(0));
    chk({tag, "_gnt_id"},      64'(gnt_id),          64'(0));
    chk({tag, "_total"},       64'(total_req_count), 64'(0));
    chk({tag, "_hit_cnt"},     64'(core_hit_cnt),    64'(0));
    chk({tag, "_miss_cnt"},    64'(core_miss_cnt),   64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    req     = '0;
    found_r = 1'b0;
    upd_r   = 1'b0;
    found_s = 1'b0;
    mlast   = NC - 1;
    tot_m   = 0;
    for (int i = 0; i < NC; i++) begin
      hit_m[i]  = 0;
      miss_m[i] = 0;
      left[i]   = 0;
    end
    rd_idx  = exp_q.size();
    r_cnt   = -1;
    r_drop  = 1'b0;
    r_trchk = 1'b0;
    cnt_chk = 1'b0;
    rnd     = 1'b0;
    #1;
    chk_reset_vals(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0, cyc;
    rst_n = 1'b0;
    req = '0;
    found_r = 1'b0; upd_r = 1'b0; found_s = 1'b0;
    for (int i = 0; i < NC; i++) addr_m[i] = '0;
    n_vec = 0; n_mis = 0; rd_idx = 0;
    cfg_kind = 0; cfg_lat = 0; cfg_lat_rnd = 1'b0;

    // Single hit on core 0, cache answers 3 cycles after trace_ready.
    do_reset("por");
    addr_m[0] = 32'h0000_1000;
    cfg_kind = 0; cfg_lat = 3;
    left = '{1, 0, 0, 0};
    run_phase(60, "single_hit");
    chk("single_total", 64'(total_req_count), 64'(1));

    // All cores held, misses: rotation 0,1,2,3,0,1,2,3.
    do_reset("fair");
    for (int i = 0; i < NC; i++) addr_m[i] = 32'h0000_0100 * (i + 1);
    glog.delete();
    cfg_kind = 1; cfg_lat = 1;
    left = '{2, 2, 2, 2};
    run_phase(200, "fairness");
    chk("fair_count", 64'(glog.size()), 64'(8));
    for (int k = 0; k < 8 && k < glog.size(); k++)
      chk($sformatf("fair_gnt[%0d]", k), 64'(glog[k]), 64'(k % NC));
`ifdef ARB_CORE_STATS_EN
    for (int i = 0; i < NC; i++)
      chk($sformatf("fair_miss[%0d]", i), 64'(core_miss_cnt[i*CW +: CW]), 64'(2));
`endif

    // Both strobes together: one ack, reported as hit.
    cfg_kind = 2; cfg_lat = 2;
    addr_m[3] = 32'hDEAD_0003;
    left[3] = 1;
    run_phase(60, "both_strobes");

    // Spurious hit strobe while idle: no ack, counters untouched.
    tick();
    found_s = 1'b1;
    tick();
    found_s = 1'b0;
    repeat (4) tick();
    chk("spurious_busy", 64'(busy), 64'(0));
    cnt_chk = 1'b1;
    tick();

    // Reset while core 2 waits for the cache, then a clean transaction.
    do_reset("pre_abort");
    cfg_kind = 4;
    addr_m[2] = 32'hCAFE_0200;
    req[2] = 1'b1;
    n0 = glog.size();
    cyc = 0;
    while (glog.size() == n0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("abort_grant_seen", 64'(glog.size()), 64'(n0 + 1));
    chk("abort_gnt_id", 64'(gnt_id), 64'(2));
    tick();
    tick();
    chk("abort_busy_in_wait", 64'(busy), 64'(1));
    do_reset("abort");
    repeat (3) tick();
    cfg_kind = 0; cfg_lat_rnd = 1'b1;
    addr_m[2] = 32'h2000_0020;
    left[2] = 1;
    run_phase(60, "post_abort");
    chk("post_abort_gnt", 64'(glog[glog.size()-1]), 64'(2));

    // 17 hits on core 1 with 4-bit counters: saturate at 15.
    do_reset("sat");
    cfg_kind = 0; cfg_lat_rnd = 1'b1;
    addr_m[1] = 32'h0001_0001;
    left[1] = 17;
    run_phase(600, "saturate");
    chk("sat_total", 64'(total_req_count), 64'(15));
`ifdef ARB_CORE_STATS_EN
    chk("sat_hit1", 64'(core_hit_cnt[1*CW +: CW]), 64'(15));
`endif

    // Randomised traffic: gaps, drops, new addresses, mixed results.
    do_reset("rand");
    rnd = 1'b1;
    cfg_kind = 3; cfg_lat_rnd = 1'b1;
    for (int i = 0; i < NC; i++) left[i] = int'($urandom_range(5, 25));
    run_phase(6000, "random");

    chk("scoreboard_drained", 64'(rd_idx), 64'(exp_q.size()));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
